// File: rtl/nf_tpu_ins_router_if.sv
// Handshake bundle for nf_tpu_ins_router: instruction input, pass-through
// output and the shared multicast slice bus with per-slice valid/ready.
interface nf_tpu_ins_router_if #(
    parameter int INS_W    = 64,
    parameter int N_SLICES = 4
);
    logic [INS_W-1:0]    in_ins;
    logic                in_ins_valid;
    logic                in_ins_ready;

    logic [INS_W-1:0]    out_ins;
    logic                out_ins_valid;
    logic                out_ins_ready;

    logic [INS_W-1:0]    out_slice_ins;
    logic [N_SLICES-1:0] out_slice_valid;
    logic [N_SLICES-1:0] out_slice_ready;

    // Environment side: produces instructions, consumes both output paths.
    modport master (
        output in_ins, in_ins_valid, out_ins_ready, out_slice_ready,
        input  in_ins_ready, out_ins, out_ins_valid, out_slice_ins, out_slice_valid
    );

    // Router side.
    modport slave (
        input  in_ins, in_ins_valid, out_ins_ready, out_slice_ready,
        output in_ins_ready, out_ins, out_ins_valid, out_slice_ins, out_slice_valid
    );
endinterface

// File: rtl/nf_tpu_ins_router.sv
// Instruction router: multicasts slice-opcode instructions to N_SLICES slices and
// forwards everything else on a registered pass-through. Optional counters: NF_TPU_ROUTER_STATS_EN.
module nf_tpu_ins_router #(
    parameter int INS_W     = 64,
    parameter int OPC_W     = 8,
    parameter int N_SLICES  = 4,
    parameter int SLICE_OPC = 5,
    parameter int FENCE_OPC = 6,
    parameter int MASK_LSB  = 8
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    nf_tpu_ins_router_if.slave   bus,
    output logic                 err_bad_mask,
    input  logic                 err_clr
`ifdef NF_TPU_ROUTER_STATS_EN
    ,
    input  logic                 stat_clr,
    output logic [31:0]          stat_slice_cnt,
    output logic [31:0]          stat_pass_cnt,
    output logic [31:0]          stat_stall_cnt
`endif
);

    logic [OPC_W-1:0]    opcode;
    logic [N_SLICES-1:0] sel_mask;
    logic                is_slice;
    logic                is_fence;
    logic                mask_zero;
    logic                pass_free;
    logic                slice_free;
    logic                fence_ok;
    logic                in_ready;
    logic                in_acc;
    logic                slice_acc;
    logic                pass_acc;
    logic                bad_acc;

    logic [INS_W-1:0]    out_ins_q, out_ins_d;
    logic                out_ins_valid_q, out_ins_valid_d;
    logic [INS_W-1:0]    out_slice_ins_q, out_slice_ins_d;
    logic [N_SLICES-1:0] pending_q, pending_d;
    logic [N_SLICES-1:0] pending_hs;
    logic                err_q, err_d;

    // ------------------------------------------------------------------
    // Classification and acceptance
    // ------------------------------------------------------------------
    always_comb begin
        opcode     = bus.in_ins[OPC_W-1:0];
        sel_mask   = bus.in_ins[MASK_LSB +: N_SLICES];
        is_slice   = (opcode == OPC_W'(SLICE_OPC));
        is_fence   = (opcode == OPC_W'(FENCE_OPC));
        mask_zero  = (sel_mask == '0);
        pass_free  = !out_ins_valid_q || bus.out_ins_ready;
        slice_free = (pending_hs == '0);
        // A fence waits until both paths are empty after this cycle's handshakes.
        fence_ok   = slice_free && pass_free;

        in_ready = pass_free;
        if (is_slice) begin
            in_ready = mask_zero || slice_free;
        end else if (is_fence) begin
            in_ready = fence_ok;
        end

        in_acc    = bus.in_ins_valid && in_ready;
        slice_acc = in_acc && is_slice && !mask_zero;
        bad_acc   = in_acc && is_slice && mask_zero;
        pass_acc  = in_acc && !is_slice;
    end

    assign bus.in_ins_ready = in_ready;

    // ------------------------------------------------------------------
    // Pass-through register
    // ------------------------------------------------------------------
    always_comb begin
        out_ins_d       = out_ins_q;
        out_ins_valid_d = out_ins_valid_q;
        if (pass_acc) begin
            out_ins_d       = bus.in_ins;
            out_ins_valid_d = 1'b1;
        end else if (bus.out_ins_ready) begin
            out_ins_valid_d = 1'b0;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            out_ins_q       <= '0;
            out_ins_valid_q <= 1'b0;
        end else begin
            out_ins_q       <= out_ins_d;
            out_ins_valid_q <= out_ins_valid_d;
        end
    end

    assign bus.out_ins       = out_ins_q;
    assign bus.out_ins_valid = out_ins_valid_q;

    // ------------------------------------------------------------------
    // Multicast slice tracker: each selected slice clears its own bit on
    // handshake; a new instruction loads only once every bit would clear.
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < N_SLICES; gi++) begin : g_slice
        assign pending_hs[gi] = pending_q[gi] && !bus.out_slice_ready[gi];
        assign pending_d[gi]  = slice_acc ? sel_mask[gi] : pending_hs[gi];
    end

    always_comb begin
        out_slice_ins_d = out_slice_ins_q;
        if (slice_acc) begin
            out_slice_ins_d = bus.in_ins;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            out_slice_ins_q <= '0;
            pending_q       <= '0;
        end else begin
            out_slice_ins_q <= out_slice_ins_d;
            pending_q       <= pending_d;
        end
    end

    assign bus.out_slice_ins   = out_slice_ins_q;
    assign bus.out_slice_valid = pending_q;

    // ------------------------------------------------------------------
    // Sticky error: clear wins over a same-cycle set.
    // ------------------------------------------------------------------
    always_comb begin
        err_d = err_q;
        if (err_clr) begin
            err_d = 1'b0;
        end else if (bad_acc) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_bad_mask = err_q;

`ifdef NF_TPU_ROUTER_STATS_EN
    // ------------------------------------------------------------------
    // Saturating event counters. Zero-mask slice instructions are still
    // accepted, so they count as slice accepts.
    // ------------------------------------------------------------------
    logic [2:0]       stat_inc;
    logic [2:0][31:0] stat_cnt;

    assign stat_inc[0] = in_acc && is_slice;
    assign stat_inc[1] = pass_acc;
    assign stat_inc[2] = bus.in_ins_valid && !in_ready;

    for (genvar gi = 0; gi < 3; gi++) begin : g_stat
        logic [31:0] cnt_q, cnt_d;

        always_comb begin
            cnt_d = cnt_q;
            if (stat_clr) begin
                cnt_d = '0;
            end else if (stat_inc[gi] && (cnt_q != 32'hFFFF_FFFF)) begin
                cnt_d = cnt_q + 32'd1;
            end
        end

        always_ff @(posedge sys_clk or negedge sys_rst_n) begin
            if (!sys_rst_n) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign stat_cnt[gi] = cnt_q;
    end

    assign stat_slice_cnt = stat_cnt[0];
    assign stat_pass_cnt  = stat_cnt[1];
    assign stat_stall_cnt = stat_cnt[2];
`endif

endmodule
